// File: rtl/reset_controller_pkg.sv
// reset_controller_pkg
//   Shared definitions for the f8 reset sequencer: cause bit positions,
//   register map, magic write values and the sequencer state type.
package reset_controller_pkg;

   // CAUSE register bit positions
   localparam int unsigned CAUSE_POR  = 0;
   localparam int unsigned CAUSE_TRAP = 1;
   localparam int unsigned CAUSE_WDT  = 2;
   localparam int unsigned CAUSE_SW   = 3;

   // Register map
   localparam logic [1:0] ADDR_CAUSE   = 2'd0;
   localparam logic [1:0] ADDR_WDTCTRL = 2'd1;
   localparam logic [1:0] ADDR_WDTKICK = 2'd2;
   localparam logic [1:0] ADDR_SWRST   = 2'd3;

   // Magic write values
   localparam logic [7:0] WDT_KICK_MAGIC = 8'h5A;
   localparam logic [7:0] SWRST_MAGIC    = 8'hA5;

   typedef enum logic {
      HOLD = 1'b0,
      RUN  = 1'b1
   } state_e;

endpackage

// File: rtl/reset_controller_watchdog_timer.sv
// watchdog_timer
//   Down-counting watchdog. Counts down once per cycle while enabled and
//   nonzero; it stops at zero rather than wrapping. A reload forces the
//   count to all ones and takes priority over counting.
// Ports:
//   clk     - system clock
//   rst     - asynchronous active-high reset (count -> all ones)
//   enable  - watchdog armed
//   reload  - set count to all ones this cycle
//   expired - armed and count has reached zero (combinational)
//   count   - upper byte of the count, the only part software can read
module watchdog_timer #(
   parameter int unsigned WDTBITS = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic       reload,
   output logic       expired,
   output logic [7:0] count
);

   logic [WDTBITS-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (reload) begin
         count_d = '1;
      end else if (enable && (count_q != '0)) begin
         count_d = count_q - WDTBITS'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '1;
      end else begin
         count_q <= count_d;
      end
   end

   assign expired = enable && (count_q == '0);
   assign count   = count_q[WDTBITS-1 -: 8];

endmodule

// File: rtl/reset_controller.sv
// reset_controller
//   Reset sequencer and watchdog for the f8 system. Holds `reset` high for
//   STRETCH cycles after power-on, a core trap, a watchdog expiry or a
//   software request, and records which of those caused it.
// Ports:
//   clk            - system clock
//   power_on_reset - asynchronous active-high reset of this block
//   trap           - core trap indication (synchronous)
//   addr           - register select: 0 CAUSE, 1 WDTCTRL, 2 WDTKICK, 3 SWRST
//   wr             - one-cycle write strobe
//   din            - write data
//   dout           - read data, combinational from addr
//   reset          - registered active-high reset to core and peripherals
module reset_controller
   import reset_controller_pkg::*;
#(
   parameter int unsigned STRETCH = 16,
   parameter int unsigned WDTBITS = 16
) (
   input  logic       clk,
   input  logic       power_on_reset,
   input  logic       trap,
   input  logic [1:0] addr,
   input  logic       wr,
   input  logic [7:0] din,
   output logic [7:0] dout,
   output logic       reset
);

   localparam logic [7:0] HOLD_INIT = 8'(STRETCH - 1);

   state_e     state_q, state_d;
   logic [7:0] hold_cnt_q, hold_cnt_d;
   logic [3:0] cause_q, cause_d;
   logic       wdt_en_q, wdt_en_d;
   logic [7:0] rst_cnt_q, rst_cnt_d;
   logic       sw_req_q, sw_req_d;
   logic       reset_q, reset_d;

   logic       wdt_reload;
   logic       wdt_expired;
   logic [7:0] wdt_count;
   logic [3:0] events;

   watchdog_timer #(
      .WDTBITS (WDTBITS)
   ) u_wdt (
      .clk     (clk),
      .rst     (power_on_reset),
      .enable  (wdt_en_q),
      .reload  (wdt_reload),
      .expired (wdt_expired),
      .count   (wdt_count)
   );

   always_comb begin
      events                = '0;
      events[CAUSE_TRAP]    = trap;
      events[CAUSE_WDT]     = wdt_expired;
      events[CAUSE_SW]      = sw_req_q;

      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      cause_d    = cause_q;
      wdt_en_d   = wdt_en_q;
      rst_cnt_d  = rst_cnt_q;
      sw_req_d   = 1'b0;
      wdt_reload = 1'b0;

      unique case (state_q)
         HOLD: begin
            if (hold_cnt_q == 8'd0) begin
               state_d = RUN;
            end else begin
               hold_cnt_d = hold_cnt_q - 8'd1;
            end
         end
         RUN: begin
            // Clear first, then OR in events, so a same-cycle event wins.
            if (wr && (addr == ADDR_CAUSE)) begin
               cause_d = cause_q & ~din[3:0];
            end
            if (|events) begin
               // Taking the transition also swallows any same-cycle
               // watchdog write or kick: expiry beats a late kick.
               state_d    = HOLD;
               hold_cnt_d = HOLD_INIT;
               cause_d    = cause_d | events;
               wdt_en_d   = 1'b0;
               if (rst_cnt_q != 8'hFF) begin
                  rst_cnt_d = rst_cnt_q + 8'd1;
               end
            end else begin
               if (wr && (addr == ADDR_WDTCTRL)) begin
                  wdt_en_d   = din[0];
                  wdt_reload = din[0];
               end
               if (wr && (addr == ADDR_WDTKICK) && (din == WDT_KICK_MAGIC)) begin
                  wdt_reload = 1'b1;
               end
               sw_req_d = wr && (addr == ADDR_SWRST) && (din == SWRST_MAGIC);
            end
         end
      endcase

      reset_d = (state_d == HOLD);
   end

   always_ff @(posedge clk or posedge power_on_reset) begin
      if (power_on_reset) begin
         state_q    <= HOLD;
         hold_cnt_q <= HOLD_INIT;
         cause_q    <= 4'b0001;
         wdt_en_q   <= 1'b0;
         rst_cnt_q  <= '0;
         sw_req_q   <= 1'b0;
         reset_q    <= 1'b1;
      end else begin
         state_q    <= state_d;
         hold_cnt_q <= hold_cnt_d;
         cause_q    <= cause_d;
         wdt_en_q   <= wdt_en_d;
         rst_cnt_q  <= rst_cnt_d;
         sw_req_q   <= sw_req_d;
         reset_q    <= reset_d;
      end
   end

   always_comb begin
      dout = '0;
      unique case (addr)
         ADDR_CAUSE:   dout = {4'b0000, cause_q};
         ADDR_WDTCTRL: dout = {7'b0000000, wdt_en_q};
         ADDR_WDTKICK: dout = wdt_count;
         ADDR_SWRST:   dout = rst_cnt_q;
      endcase
   end

   assign reset = reset_q;

endmodule

// File: tb/tb_reset_controller.sv
// tb_reset_controller
//   Self-checking bench for reset_controller (STRETCH=16, WDTBITS=8).
//   Expected values are queued as stimulus is applied and popped when the
//   corresponding DUT output is sampled.
module tb_reset_controller;
   import reset_controller_pkg::*;

   logic       clk = 1'b0;
   logic       power_on_reset;
   logic       trap;
   logic [1:0] addr;
   logic       wr;
   logic [7:0] din;
   logic [7:0] dout;
   logic       reset;

   reset_controller #(
      .STRETCH (16),
      .WDTBITS (8)
   ) dut (
      .clk            (clk),
      .power_on_reset (power_on_reset),
      .trap           (trap),
      .addr           (addr),
      .wr             (wr),
      .din            (din),
      .dout           (dout),
      .reset          (reset)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;

   exp_t        exp_q[$];
   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input string tag, input logic [31:0] v);
      exp_t e;
      e.tag = tag;
      e.val = v;
      exp_q.push_back(e);
   endtask

   task automatic pop_check(input logic [31:0] obs);
      exp_t e;
      if (exp_q.size() == 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL scoreboard_empty: observed 0x%0h expected none", obs);
      end else begin
         e = exp_q.pop_front();
         check_val(e.tag, obs, e.val);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic read_expect(input string tag, input logic [1:0] a, input logic [7:0] exp);
      addr = a;
      push_exp(tag, {24'b0, exp});
      #1;
      pop_check({24'b0, dout});
   endtask

   task automatic wr_reg(input logic [1:0] a, input logic [7:0] d);
      addr = a;
      din  = d;
      wr   = 1'b1;
      tick();
      wr   = 1'b0;
      din  = '0;
   endtask

   task automatic check_reset(input string tag, input logic exp);
      push_exp(tag, {31'b0, exp});
      tick();
      pop_check({31'b0, reset});
   endtask

   // Called just after the edge where reset rose: 15 more high, then low.
   task automatic expect_stretch(input string tag);
      for (int unsigned k = 1; k < 16; k++) check_reset(tag, 1'b1);
      check_reset({tag, "_fall"}, 1'b0);
   endtask

   task automatic run_wdt_to_zero(input string tag);
      wr_reg(ADDR_WDTCTRL, 8'h01);
      for (int unsigned k = 1; k <= 255; k++) check_reset(tag, 1'b0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: observed no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      power_on_reset = 1'b1;
      trap = 1'b0;
      wr   = 1'b0;
      addr = '0;
      din  = '0;

      // Power-on
      for (int unsigned k = 0; k < 5; k++) check_reset("por_held", 1'b1);
      read_expect("por_held_cause", ADDR_CAUSE, 8'h01);
      read_expect("por_held_rcnt", ADDR_SWRST, 8'h00);
      power_on_reset = 1'b0;
      for (int unsigned k = 1; k <= 16; k++) check_reset("por_stretch", k < 16);
      read_expect("por_cause", ADDR_CAUSE, 8'h01);
      read_expect("por_rcnt", ADDR_SWRST, 8'h00);
      read_expect("por_wdtctrl", ADDR_WDTCTRL, 8'h00);
      read_expect("por_wdtcount", ADDR_WDTKICK, 8'hFF);

      // Trap
      trap = 1'b1;
      check_reset("trap_rise", 1'b1);
      trap = 1'b0;
      expect_stretch("trap_stretch");
      read_expect("trap_cause", ADDR_CAUSE, 8'h03);
      read_expect("trap_rcnt", ADDR_SWRST, 8'h01);
      wr_reg(ADDR_CAUSE, 8'h02);
      read_expect("cause_clear", ADDR_CAUSE, 8'h01);

      // Watchdog expiry without kicks
      wr_reg(ADDR_WDTCTRL, 8'h01);
      read_expect("wdt_en", ADDR_WDTCTRL, 8'h01);
      read_expect("wdt_reloaded", ADDR_WDTKICK, 8'hFF);
      for (int unsigned k = 1; k <= 255; k++) check_reset("wdt_counting", 1'b0);
      read_expect("wdt_at_zero", ADDR_WDTKICK, 8'h00);
      check_reset("wdt_fire", 1'b1);
      expect_stretch("wdt_stretch");
      read_expect("wdt_cause", ADDR_CAUSE, 8'h05);
      read_expect("wdt_disabled", ADDR_WDTCTRL, 8'h00);
      read_expect("wdt_rcnt", ADDR_SWRST, 8'h02);

      // Watchdog kicked every 200 cycles
      wr_reg(ADDR_CAUSE, 8'h0F);
      read_expect("cause_all_clear", ADDR_CAUSE, 8'h00);
      wr_reg(ADDR_WDTCTRL, 8'h01);
      for (int unsigned r = 0; r < 4; r++) begin
         for (int unsigned k = 1; k < 200; k++) check_reset("kick_noreset", 1'b0);
         wr_reg(ADDR_WDTKICK, WDT_KICK_MAGIC);
         read_expect("kick_count", ADDR_WDTKICK, 8'hFF);
      end
      wr_reg(ADDR_WDTKICK, 8'h5B);
      read_expect("bad_kick_ignored", ADDR_WDTKICK, 8'hFE);
      wr_reg(ADDR_WDTCTRL, 8'h00);
      read_expect("kick_disabled", ADDR_WDTCTRL, 8'h00);
      read_expect("kick_rcnt", ADDR_SWRST, 8'h02);

      // Software request
      wr_reg(ADDR_SWRST, 8'h33);
      for (int unsigned k = 0; k < 3; k++) check_reset("sw_bad_magic", 1'b0);
      read_expect("sw_bad_rcnt", ADDR_SWRST, 8'h02);
      wr_reg(ADDR_SWRST, SWRST_MAGIC);
      push_exp("sw_req_edge", 32'd0);
      pop_check({31'b0, reset});
      check_reset("sw_rise", 1'b1);
      expect_stretch("sw_stretch");
      read_expect("sw_cause", ADDR_CAUSE, 8'h08);
      read_expect("sw_rcnt", ADDR_SWRST, 8'h03);

      // Trap coincident with watchdog expiry
      wr_reg(ADDR_CAUSE, 8'h0F);
      run_wdt_to_zero("sim_counting");
      trap = 1'b1;
      check_reset("sim_rise", 1'b1);
      trap = 1'b0;
      expect_stretch("sim_stretch");
      read_expect("sim_cause", ADDR_CAUSE, 8'h06);
      read_expect("sim_rcnt", ADDR_SWRST, 8'h04);

      // Kick in the expiry cycle is too late
      wr_reg(ADDR_CAUSE, 8'h0F);
      run_wdt_to_zero("late_counting");
      addr = ADDR_WDTKICK;
      din  = WDT_KICK_MAGIC;
      wr   = 1'b1;
      check_reset("late_kick_rise", 1'b1);
      wr   = 1'b0;
      expect_stretch("late_kick_stretch");
      read_expect("late_kick_cause", ADDR_CAUSE, 8'h04);
      read_expect("late_kick_rcnt", ADDR_SWRST, 8'h05);

      // CAUSE clear coincident with trap
      wr_reg(ADDR_CAUSE, 8'h0F);
      addr = ADDR_CAUSE;
      din  = 8'h02;
      wr   = 1'b1;
      trap = 1'b1;
      check_reset("clr_trap_rise", 1'b1);
      wr   = 1'b0;
      trap = 1'b0;
      expect_stretch("clr_trap_stretch");
      read_expect("clr_trap_cause", ADDR_CAUSE, 8'h02);
      read_expect("clr_trap_rcnt", ADDR_SWRST, 8'h06);

      // Power-on reset in the middle of HOLD
      trap = 1'b1;
      check_reset("abort_rise", 1'b1);
      trap = 1'b0;
      for (int unsigned k = 0; k < 5; k++) check_reset("abort_hold", 1'b1);
      #2;
      power_on_reset = 1'b1;
      #1;
      read_expect("abort_rcnt", ADDR_SWRST, 8'h00);
      read_expect("abort_cause", ADDR_CAUSE, 8'h01);
      for (int unsigned k = 0; k < 3; k++) check_reset("abort_held", 1'b1);
      power_on_reset = 1'b0;
      for (int unsigned k = 1; k <= 16; k++) check_reset("abort_stretch", k < 16);

      // Reset count saturation
      for (int unsigned i = 0; i < 300; i++) begin
         trap = 1'b1;
         tick();
         trap = 1'b0;
         for (int unsigned k = 0; k < 16; k++) tick();
      end
      push_exp("sat_run", 32'd0);
      pop_check({31'b0, reset});
      read_expect("sat_rcnt", ADDR_SWRST, 8'hFF);
      read_expect("sat_cause", ADDR_CAUSE, 8'h03);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
